data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the data-memory load/store interface: accepts one request at a time
//  from a pipelined core's memory-stage initiator over a valid/ready handshake.
//  Performs the access after a fixed latency and returns the result over a second handshake.
//  Provides byte/half/word access with sign/zero extension using AddressingControl encoding.
//  Models multi-cycle data RAM so the core's stall path can be exercised.
// PARAMETERS
//  ADDR_WIDTH  17  byte-address bits implemented; storage = 2**(ADDR_WIDTH-2) 32-bit words
//  LATENCY     2   cycles from request accept to resp_valid; legal range 1..15
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; equals (state==IDLE)
//  req_write   in   1   1=store, 0=load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low bytes used for sb/sh
//  req_ctrl    in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 stores
//  resp_valid  out  1   response present
//  resp_ready  in   1   initiator accepts response
//  resp_rdata  out  32  load result (extended); 0 for stores and errors
//  resp_err    out  1   misaligned, out-of-range or illegal req_ctrl
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
//    req_ready=1 once in IDLE. RAM contents not reset.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: accept when req_valid&&req_ready at edge N; latch write, addr, wdata, ctrl.
//    Load counter=LATENCY-1; next state BUSY (LATENCY=1: straight to RESP, access done at edge N).
//  - BUSY: counter decrements each edge. On edge with counter==0: perform access, register rdata/err, go RESP.
//    Writes commit on that edge only.
//  - Timing: resp_valid first high after edge N+LATENCY. Accepted request yields exactly one response.
//  - RESP: resp_valid=1; rdata/err held stable until resp_valid&&resp_ready.
//    On that edge: resp_valid=0, go IDLE. Next request accepted no earlier than following edge.
//  - req_valid ignored outside IDLE; request fields only sampled at accept.
//  - Little-endian. Byte lane = addr[1:0]; half lane = addr[1].
//    b/h sign-extend, bu/hu zero-extend. sb/sh update only addressed bytes.
//  - Errors (resp_err=1, no RAM write, rdata=0):
//    h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0; addr>=2**ADDR_WIDTH; ctrl 011/110/111;
//    store with ctrl 100/101.
//  - Error is still a normal response with same latency and handshake.
//  - Reset mid-operation: any state returns to IDLE. Uncommitted store discarded.
//    Pending response dropped.
//  - resp_ready held low indefinitely: stays in RESP, no new request accepted, no RAM change.
// TESTING
//  1 sw addr=0x100 wdata=0xDEADBEEF, then lw 0x100, LATENCY=2
//    -> store resp err=0 rdata=0; load resp_valid 2 cycles after accept, rdata=0xDEADBEEF.
//  2 after (1): lb 0x103 -> 0xFFFFFFDE; lbu 0x103 -> 0x000000DE;
//    lh 0x100 -> 0xFFFFBEEF; lhu 0x102 -> 0x0000DEAD.
//  3 sb 0x101 wdata=0x12, then lw 0x100 -> 0xDEAD12EF.
//    sh 0x102 wdata=0x5678, then lw 0x100 -> 0x567812EF.
//  4 lw 0x102; sh 0x101; ctrl=011; lw 0x20000
//    -> each resp_err=1 rdata=0; word at 0x100 unchanged.
//  5 resp_ready low 5 cycles during load response
//    -> resp_valid/rdata stable; req_valid pulses ignored (req_ready=0); single response on release.
//  6 sw 0x200 0xCAFEF00D then rst_n low 1 cycle while BUSY (counter>0)
//    -> resp_valid=0, req_ready=1 after reset; lw 0x200 returns prior contents, not 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed access latency,
// byte/half/word loads and stores with sign/zero extension.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**(ADDR_WIDTH-2)];

    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [2:0]            acc_ctrl;
    logic [ADDR_WIDTH-3:0] widx;
    logic                  ctrl_bad, misal, oor, acc_err;
    logic [31:0]           rword, rsh, load_val, wlanes;
    logic [3:0]            be;
    logic                  do_acc, mem_we;

    // With LATENCY=1 the access happens on the accept edge, straight from the ports
    assign acc_write = (state_q == IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_ctrl  = (state_q == IDLE) ? req_ctrl  : ctrl_q;
    assign widx      = acc_addr[ADDR_WIDTH-1:2];

    always_comb begin
        ctrl_bad = acc_write ? (acc_ctrl[2] || acc_ctrl[1:0] == 2'b11)
                             : (acc_ctrl == 3'b011 || acc_ctrl[2:1] == 2'b11);
        misal    = (acc_ctrl[1:0] == 2'b01 && acc_addr[0]) ||
                   (acc_ctrl[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
        oor      = (acc_addr >> ADDR_WIDTH) != 32'd0;
        acc_err  = ctrl_bad || misal || oor;
    end

    always_comb begin
        rword    = mem[widx];
        rsh      = rword >> {acc_addr[1:0], 3'b000};
        load_val = 32'd0;
        case (acc_ctrl)
            3'b000:  load_val = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  load_val = {{16{rsh[15]}}, rsh[15:0]};
            3'b010:  load_val = rsh;
            3'b100:  load_val = {24'd0, rsh[7:0]};
            3'b101:  load_val = {16'd0, rsh[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        be     = 4'b1111;
        wlanes = acc_wdata;
        case (acc_ctrl[1:0])
            2'b00: begin
                be     = 4'b0001 << acc_addr[1:0];
                wlanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be     = acc_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{acc_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = acc_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        do_acc  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    ctrl_d  = req_ctrl;
                    if (LATENCY == 1) begin
                        do_acc  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    do_acc  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (do_acc) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : load_val;
            mem_we  = acc_write && !acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ctrl_q  <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: word/sub-word access, errors,
// response back-pressure and reset during a pending store.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_ctrl = 3'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Issue one request, wait for its response, accept it; lat = edges from accept to resp_valid
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] c, output logic [31:0] rd,
                          output logic e, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_ctrl = c;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
        end
        checks++;
        if (resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'd0 || lat != 2) begin
            errors++; $display("FAIL sw_resp got err=%b rd=%h lat=%0d exp err=0 rd=0 lat=2", e, rd, lat);
        end
        do_req(1'b0, 32'h100, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'hDEADBEEF || lat != 2) begin
            errors++; $display("FAIL lw_resp got err=%b rd=%h lat=%0d exp err=0 rd=deadbeef lat=2", e, rd, lat);
        end
    endtask

    task automatic test_subword;
        logic [31:0] rd; logic e; int lat;
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h100, 32'h102};
        logic [2:0]  ctls  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, addrs[i], 32'd0, ctls[i], rd, e, lat);
            checks++;
            if (e !== 1'b0 || rd !== exps[i]) begin
                errors++;
                $display("FAIL subword_load%0d got err=%b rd=%h exp err=0 rd=%h", i, e, rd, exps[i]);
            end
        end
    endtask

    task automatic test_store_merge;
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 32'h101, 32'h00000012, 3'b000, rd, e, lat);
        do_req(1'b0, 32'h100, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD12EF) begin
            errors++; $display("FAIL sb_merge got=%h exp=dead12ef", rd);
        end
        do_req(1'b1, 32'h102, 32'h00005678, 3'b001, rd, e, lat);
        do_req(1'b0, 32'h100, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (rd !== 32'h567812EF) begin
            errors++; $display("FAIL sh_merge got=%h exp=567812ef", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e; int lat;
        logic        ws [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] as [5] = '{32'h102, 32'h101, 32'h100, 32'h20000, 32'h100};
        logic [2:0]  cs [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        for (int i = 0; i < 5; i++) begin
            do_req(ws[i], as[i], 32'hFFFFFFFF, cs[i], rd, e, lat);
            checks++;
            if (e !== 1'b1 || rd !== 32'd0 || lat != 2) begin
                errors++;
                $display("FAIL err_case%0d got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=2", i, e, rd, lat);
            end
        end
        do_req(1'b0, 32'h100, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (rd !== 32'h567812EF) begin
            errors++; $display("FAIL err_no_write got=%h exp=567812ef", rd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic e; int lat; int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_ctrl = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100;
            req_wdata = 32'h0BAD0000 + i; req_ctrl = 3'b010;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h567812EF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%b rd=%h rdy=%b exp valid=1 rd=567812ef rdy=0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL release got valid=%b rdy=%b exp valid=0 rdy=1", resp_valid, req_ready);
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL single_resp got extra=%0d exp=0", n);
        end
        do_req(1'b0, 32'h100, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (rd !== 32'h567812EF) begin
            errors++; $display("FAIL hold_no_write got=%h exp=567812ef", rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic e; int lat; int n;
        do_req(1'b1, 32'h200, 32'h11223344, 3'b010, rd, e, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
        req_wdata = 32'hCAFEF00D; req_ctrl = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got valid=%b rdy=%b exp valid=0 rdy=1", resp_valid, req_ready);
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL mid_reset_dropped got=%0d exp=0", n);
        end
        do_req(1'b0, 32'h200, 32'd0, 3'b010, rd, e, lat);
        checks++;
        if (rd !== 32'h11223344) begin
            errors++; $display("FAIL mid_reset_discard got=%h exp=11223344", rd);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_subword;
        test_store_merge;
        test_errors;
        test_backpressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
